instr_fetch_pc_unit: RTL
========================

// Module: instr_fetch_pc_unit
// PURPOSE
//  Owns the program counter and instruction register of the multicycle CPU.
//  Fetches one instruction per fetch_start pulse over a req/ack instruction-memory handshake.
//  Feeds opcode/funct/imm/target fields to the control FSM downstream.
//  Consumes the FSM's jump/beq/bne/PC-write strobes to compute the next PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  ADDR_W     32             PC and imem address width (word-aligned, bits[1:0]=0)
// PORTS
//  clk          in   1       system clock, all state on posedge
//  reset        in   1       synchronous, active-high
//  fetch_start  in   1       FSM instrReg strobe; start fetch at current PC
//  imem_req     out  1       instruction-memory read request
//  imem_addr    out  ADDR_W  fetch address, held stable while imem_req=1
//  imem_ack     in   1       memory accepts request; imem_rdata valid this cycle
//  imem_rdata   in   32      fetched instruction word
//  fetch_busy   out  1       high while a fetch is outstanding (future FSM stall)
//  ir_valid     out  1       IR holds a fetched instruction not yet superseded
//  opcode       out  6       IR[31:26]
//  funct        out  6       IR[5:0]
//  rs,rt,rd     out  5 each  IR[25:21], IR[20:16], IR[15:11]
//  imm          out  16      IR[15:0]
//  pc_we        in   1       FSM PCReg; may stay high several consecutive cycles
//  jump,beq,bne in   1 each  FSM branch/jump controls
//  zero         in   1       ALU zero flag from EX
//  rs_data      in   32      register-file rs value (JR target)
//  pc           out  ADDR_W  current PC
//  pc_plus4     out  ADDR_W  pc+4, combinational; JAL link value
// BEHAVIOUR
//  Reset: pc=RESET_PC, IR=0, imem_req=0, fetch_busy=0, ir_valid=0, state IDLE, upd_done=0.
//  Fetch FSM, 2 states:
//   IDLE: fetch_start=1 -> REQ; imem_req=1 and imem_addr=pc from the next cycle.
//   REQ: imem_req=1; imem_addr frozen at the PC captured on entry.
//        imem_ack=1 -> IR<=imem_rdata, ir_valid<=1, upd_done<=0, -> IDLE.
//        No timeout; ack may arrive any number of cycles later. Minimum latency: start->IR = 2 cycles.
//   fetch_start while in REQ is ignored (no queueing).
//   fetch_start in IDLE clears ir_valid at once; fetch_busy = (state==REQ).
//  PC update: only the first cycle with pc_we=1 after each IR load takes effect (upd_done set).
//   Later pc_we cycles for the same instruction are no-ops.
//   Next-PC priority:
//    1 jump & opcode==0 & funct==6'h08 (JR)     -> rs_data
//    2 jump (J/JAL)                              -> {pc_plus4[31:28], IR[25:0], 2'b00}
//    3 (beq & zero) | (bne & ~zero)              -> pc_plus4 + {{14{imm[15]}}, imm, 2'b00}
//    4 otherwise                                 -> pc_plus4
//   All adds are modulo 2^ADDR_W; wrap from 32'hFFFF_FFFC to 0 is silent.
//  pc_we while state==REQ is ignored and upd_done is unchanged. imem_addr never changes mid-request.
//  fetch_start and an effective pc_we in the same cycle: PC updates first; the fetch uses the new PC.
//  reset during REQ: the request drops next cycle. A late imem_ack after reset is ignored (state IDLE).
//  Field outputs decode the IR combinationally; they are stable from IR load until the next IR load.
// STRUCTURE
//  Shared package/header: opcode/funct defines (J, JAL, JR, BEQ, BNE, Rtype).
//   Also fetch-state encodings, RESET_PC default.
//  One sub-module: next_pc_calc (combinational priority mux + adders).
//   Top keeps PC/IR registers, fetch FSM and upd_done flag.
// TESTING
//  1 Reset, hold fetch_start=0 -> pc=0, imem_req=0, ir_valid=0, fetch_busy=0 for 5 cycles.
//  2 pc=0x10, fetch_start, ack after 3 cycles with 0x1109_0004 (beq) -> imem_addr=0x10 throughout.
//    Expect opcode=4, imm=4. Then pc_we, beq=1, zero=1 -> pc=0x24.
//  3 Same beq with zero=0 -> pc=0x14.
//    Then pc_we high 3 cycles, no new fetch -> pc stays 0x14.
//  4 pc=0x4000_0008, IR=J target 26'h0000_100, pc_we, jump=1 -> pc=0x4000_0400.
//    pc_plus4=0x4000_000C before update.
//  5 JR: IR opcode 0, funct 0x08, rs_data=0x0000_0080, jump=1, pc_we -> pc=0x80.
//    Fetch from pc=0xFFFF_FFFC with no branch -> next pc=0.
//  6 reset asserted 1 cycle into REQ, ack 2 cycles later -> imem_req=0 after reset.
//    Expect IR unchanged (0), ir_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pc_unit_pkg.sv
// Shared encodings for the fetch/PC unit: instruction layout, opcodes, fetch states.
package instr_fetch_pc_unit_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05
    } opcode_e;

    typedef enum logic [5:0] {
        FN_JR   = 6'h08,
        FN_JALR = 6'h09
    } funct_e;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_e;

    // R-type view of the instruction register; I/J fields are re-sliced from it.
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    function automatic logic is_jr(input instr_t ir);
        return (ir.opcode == 6'(OP_RTYPE)) && (ir.funct == 6'(FN_JR));
    endfunction

endpackage

// File: rtl/instr_fetch_pc_unit_next_pc_calc.sv
// Combinational next-PC priority mux: JR, J/JAL, taken branch, sequential.
module next_pc_calc
    import instr_fetch_pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  instr_t            ir,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              zero,
    input  logic [31:0]       rs_data,
    output logic [ADDR_W-1:0] pc_plus4_c,
    output logic [ADDR_W-1:0] next_pc_c
);

    localparam int unsigned SEXT_W = ADDR_W - 18;

    logic [15:0]       imm;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic              br_taken;

    assign imm        = {ir.rd, ir.shamt, ir.funct};
    assign pc_plus4_c = pc + ADDR_W'(4);
    assign br_off     = {{SEXT_W{imm[15]}}, imm, 2'b00};
    assign br_target  = pc_plus4_c + br_off;
    assign j_target   = {pc_plus4_c[ADDR_W-1:28], ir.rs, ir.rt, imm, 2'b00};
    assign br_taken   = (beq && zero) || (bne && !zero);

    always_comb begin
        next_pc_c = pc_plus4_c;
        if (jump && is_jr(ir)) begin
            next_pc_c = ADDR_W'(rs_data);
        end else if (jump) begin
            next_pc_c = j_target;
        end else if (br_taken) begin
            next_pc_c = br_target;
        end
    end

endmodule

// File: rtl/instr_fetch_pc_unit.sv
// Program counter, instruction register and the req/ack instruction-fetch FSM
// of the multicycle CPU.
module instr_fetch_pc_unit
    import instr_fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              fetch_busy,
    output logic              ir_valid,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm,
    input  logic              pc_we,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              zero,
    input  logic [31:0]       rs_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] addr_q;
    instr_t            ir_q;
    logic              req_q;
    logic              busy_q;
    logic              ir_valid_q;
    logic              upd_done_q;

    logic [ADDR_W-1:0] next_pc_c;
    logic              pc_upd_c;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_calc (
        .pc         (pc_q),
        .ir         (ir_q),
        .jump       (jump),
        .beq        (beq),
        .bne        (bne),
        .zero       (zero),
        .rs_data    (rs_data),
        .pc_plus4_c (pc_plus4),
        .next_pc_c  (next_pc_c)
    );

    // Only the first PC write per loaded instruction counts, and never mid-fetch.
    assign pc_upd_c = pc_we && !upd_done_q && (state_q == FETCH_IDLE);
    assign pc_d     = pc_upd_c ? next_pc_c : pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            addr_q     <= ADDR_W'(RESET_PC);
            ir_q       <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            ir_valid_q <= 1'b0;
            upd_done_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (pc_upd_c) begin
                upd_done_q <= 1'b1;
            end
            case (state_q)
                FETCH_IDLE: begin
                    // A same-cycle PC write is folded in, so the fetch uses the new PC.
                    if (fetch_start) begin
                        state_q    <= FETCH_REQ;
                        req_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        addr_q     <= pc_d;
                        ir_valid_q <= 1'b0;
                    end
                end
                FETCH_REQ: begin
                    if (imem_ack) begin
                        state_q    <= FETCH_IDLE;
                        req_q      <= 1'b0;
                        busy_q     <= 1'b0;
                        ir_q       <= instr_t'(imem_rdata);
                        ir_valid_q <= 1'b1;
                        upd_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FETCH_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign fetch_busy = busy_q;
    assign ir_valid   = ir_valid_q;
    assign pc         = pc_q;

    assign opcode = ir_q.opcode;
    assign funct  = ir_q.funct;
    assign rs     = ir_q.rs;
    assign rt     = ir_q.rt;
    assign rd     = ir_q.rd;
    assign imm    = {ir_q.rd, ir_q.shamt, ir_q.funct};

endmodule
